// File: rtl/etx_protocol_ser.sv
// eLink transmit serializer: 104-bit emesh packet -> seven 16-bit wire words per frame.
// Define ETX_BURST_EN to merge sequential double-word writes into bursts.
module etx_protocol_ser #(
   parameter int PW = 104
) (
   input  logic          tx_lclk,
   input  logic          etx_io_reset,
   input  logic          tx_access,
   input  logic [PW-1:0] tx_packet,
   input  logic          tx_burst,
   output logic          tx_wait,
   input  logic          tx_wr_wait,
   input  logic          tx_rd_wait,
   output logic          tx_frame,
   output logic [15:0]   tx_word,
   output logic          tx_busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEAD,
      ST_BODY,
      ST_GAP
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           frame_q, frame_d;
   logic [15:0]    word_q, word_d;
   logic           pend_vld_q, pend_vld_d;
   logic [PW-1:1]  pend_pkt_q;
   logic [PW-1:1]  act_pkt_q;
   logic [1:0]     wr_sync_q, rd_sync_q;
   logic           accept, xfer, start_ok, burst_ok;
   logic           wr_s, rd_s;
   logic           unused_pkt_bits;

   // Builds the 112-bit on-wire sample image and returns word k of it.
   function automatic logic [15:0] wire_word(input logic [PW-1:1] p, input logic [2:0] k);
      logic [111:0] s;
      logic [111:0] sh;
      s = {p[79:72],  p[87:80],  p[95:88],  p[103:96],
           p[47:40],  p[55:48],  p[63:56],  p[71:64],
           p[11:8],   p[3:2],    p[1],      1'b1,
           p[19:12],  p[27:20],  p[35:28],
           p[7:4],    p[39:36],  8'h00};
      sh = s >> {k, 4'b0000};
      return sh[15:0];
   endfunction

   assign wr_s = wr_sync_q[1];
   assign rd_s = rd_sync_q[1];

   assign accept   = tx_access & ~pend_vld_q;
   assign start_ok = pend_vld_q & ~(pend_pkt_q[1] ? wr_s : rd_s);

`ifdef ETX_BURST_EN
   logic pend_burst_q;

   assign burst_ok = pend_vld_q & pend_burst_q & ~wr_s
                   & act_pkt_q[1]  & (act_pkt_q[3:2] == 2'b11)
                   & pend_pkt_q[1] & (pend_pkt_q[3:2] == 2'b11)
                   & (act_pkt_q[7:4] == pend_pkt_q[7:4])
                   & (pend_pkt_q[39:8] == (act_pkt_q[39:8] + 32'd8));

   always_ff @(posedge tx_lclk or posedge etx_io_reset) begin
      if (etx_io_reset) begin
         pend_burst_q <= 1'b0;
      end else if (accept) begin
         pend_burst_q <= tx_burst;
      end
   end

   assign unused_pkt_bits = tx_packet[0];
`else
   assign burst_ok        = 1'b0;
   assign unused_pkt_bits = ^{tx_packet[0], tx_burst};
`endif

   // Output registers hold the word currently on the wire; state_q describes that word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = 1'b0;
      word_d  = 16'h0000;
      xfer    = 1'b0;
      case (state_q)
         ST_IDLE, ST_GAP: begin
            // The gap cycle already provides the idle slot, so a frame may start right after it.
            if (start_ok) begin
               state_d = ST_HEAD;
               cnt_d   = 3'd0;
               frame_d = 1'b1;
               word_d  = wire_word(pend_pkt_q, 3'd0);
               xfer    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HEAD: begin
            frame_d = 1'b1;
            cnt_d   = cnt_q + 3'd1;
            word_d  = wire_word(act_pkt_q, cnt_q + 3'd1);
            if (cnt_q == 3'd2) begin
               state_d = ST_BODY;
            end
         end
         ST_BODY: begin
            if (cnt_q != 3'd6) begin
               frame_d = 1'b1;
               cnt_d   = cnt_q + 3'd1;
               word_d  = wire_word(act_pkt_q, cnt_q + 3'd1);
            end else if (burst_ok) begin
               frame_d = 1'b1;
               cnt_d   = 3'd3;
               word_d  = wire_word(pend_pkt_q, 3'd3);
               xfer    = 1'b1;
            end else begin
               state_d = ST_GAP;
               cnt_d   = 3'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   assign pend_vld_d = accept | (pend_vld_q & ~xfer);

   always_ff @(posedge tx_lclk or posedge etx_io_reset) begin
      if (etx_io_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         frame_q    <= 1'b0;
         word_q     <= 16'h0000;
         pend_vld_q <= 1'b0;
         pend_pkt_q <= '0;
         act_pkt_q  <= '0;
         wr_sync_q  <= 2'b00;
         rd_sync_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         word_q     <= word_d;
         pend_vld_q <= pend_vld_d;
         wr_sync_q  <= {wr_sync_q[0], tx_wr_wait};
         rd_sync_q  <= {rd_sync_q[0], tx_rd_wait};
         if (accept) begin
            pend_pkt_q <= tx_packet[PW-1:1];
         end
         if (xfer) begin
            act_pkt_q <= pend_pkt_q;
         end
      end
   end

   assign tx_wait  = pend_vld_q;
   assign tx_frame = frame_q;
   assign tx_word  = word_q;
   assign tx_busy  = pend_vld_q | (state_q != ST_IDLE);

endmodule
